// File: rtl/pipeline_pkg.sv
// pipeline_pkg: definitions shared by the pipeline stages.
//   - Opcode constants for the two instruction classes decoded today.
//   - Bit positions of the instruction fields inside a 32-bit RV32 word.
//   - id_ex_ctrl_t: control bundle carried from decode into execute.
//   - decode_ctrl(): maps opcode/funct3 onto that control bundle.
package pipeline_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;

  // Field positions (LSB of each field) inside the instruction word.
  localparam int OPC_LSB    = 0;
  localparam int OPC_W      = 7;
  localparam int RD_LSB     = 7;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_W   = 3;
  localparam int RS1_LSB    = 15;
  localparam int IMM_LSB    = 20;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       illegal;
    logic [2:0] alu_op;
  } id_ex_ctrl_t;

  // Unknown opcodes are flagged illegal and never write or read memory.
  function automatic id_ex_ctrl_t decode_ctrl(input logic [6:0] opcode,
                                              input logic [2:0] funct3);
    id_ex_ctrl_t c;
    c.alu_op = funct3;
    case (opcode)
      OPC_OP_IMM: begin
        c.reg_write = 1'b1;
        c.mem_read  = 1'b0;
        c.illegal   = 1'b0;
      end
      OPC_LOAD: begin
        c.reg_write = 1'b1;
        c.mem_read  = 1'b1;
        c.illegal   = 1'b0;
      end
      default: begin
        c.reg_write = 1'b0;
        c.mem_read  = 1'b0;
        c.illegal   = 1'b1;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hazard_unit.sv
// hazard_unit: load-use hazard detection for the decode stage.
// Ports:
//   ifid_valid  in   IF/ID holds a live instruction
//   rs1_used    in   decoded instruction reads rs1
//   rs1         in   rs1 index of the IF/ID instruction
//   ex_valid    in   ID/EX holds a live instruction
//   ex_mem_read in   ID/EX instruction is a load
//   ex_rd       in   destination of the ID/EX instruction
//   flush       in   branch flush from execute
//   hazard      out  load result needed before it exists (bubble ID/EX)
//   stall       out  hold fetch and IF/ID; suppressed by flush
module hazard_unit #(
  parameter int REG_ADDR_W = 3
) (
  input  logic                  ifid_valid,
  input  logic                  rs1_used,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  flush,
  output logic                  hazard,
  output logic                  stall
);

  // Load-use detection; a flush discards the dependent instruction so no stall is needed.
  always_comb begin
    hazard = ifid_valid & rs1_used & ex_valid & ex_mem_read & (ex_rd == rs1);
    stall  = hazard & ~flush;
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: instruction-decode pipeline stage between fetch and execute.
// Holds the IF/ID register, drives the register-file read address, and
// registers operand (with same-cycle write-back bypass), immediate and
// control into the ID/EX register. Load-use hazards stall fetch and insert
// one bubble; a branch flush from execute kills IF/ID and ID/EX.
// Ports:
//   clk, reset                         clock, async active-high reset
//   if_valid, if_instr, if_pc          fetched instruction
//   stall                              hold fetch (re-present same instr)
//   flush                              branch taken in execute
//   reg_read_addr / reg_read_data      register-file read port
//   wb_reg_write_en, wb_addr, wb_data  write-back port (bypass source)
//   ex_*                               registered ID/EX payload and control
module decode_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 3,
  parameter int PC_W       = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_valid,
  input  logic [31:0]           if_instr,
  input  logic [PC_W-1:0]       if_pc,
  output logic                  stall,
  input  logic                  flush,
  output logic [REG_ADDR_W-1:0] reg_read_addr,
  input  logic [DATA_W-1:0]     reg_read_data,
  input  logic                  wb_reg_write_en,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  output logic                  ex_valid,
  output logic [PC_W-1:0]       ex_pc,
  output logic [DATA_W-1:0]     ex_rs1_data,
  output logic [DATA_W-1:0]     ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [2:0]            ex_alu_op,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_illegal
);

  logic [31:0]           ifid_instr_r;
  logic [PC_W-1:0]       ifid_pc_r;
  logic                  ifid_valid_r;

  logic [OPC_W-1:0]      opcode_s;
  logic [REG_ADDR_W-1:0] rd_s;
  logic [REG_ADDR_W-1:0] rs1_s;
  logic [FUNCT3_W-1:0]   funct3_s;
  logic [DATA_W-1:0]     imm_s;
  logic [DATA_W-1:0]     rs1_data_s;
  id_ex_ctrl_t           ctrl_s;
  logic                  rs1_used_s;
  logic                  hazard_s;
  logic                  stall_s;
  logic                  unused_instr_s;

  // Only some instruction bits feed decode; fold the whole word so none dangle.
  assign unused_instr_s = ^ifid_instr_r;

  // Field extraction, decode and write-back bypass of the rs1 operand.
  always_comb begin
    opcode_s   = ifid_instr_r[OPC_LSB +: OPC_W];
    rd_s       = ifid_instr_r[RD_LSB +: REG_ADDR_W];
    funct3_s   = ifid_instr_r[FUNCT3_LSB +: FUNCT3_W];
    rs1_s      = ifid_instr_r[RS1_LSB +: REG_ADDR_W];
    imm_s      = ifid_instr_r[IMM_LSB +: DATA_W];
    ctrl_s     = decode_ctrl(opcode_s, funct3_s);
    // Both legal opcodes read rs1; illegal ones read nothing.
    rs1_used_s = ~ctrl_s.illegal;
    // The register file is written at the same edge we capture, so it still
    // returns the old value; take the write-back data directly instead.
    if (wb_reg_write_en && (wb_addr == rs1_s)) begin
      rs1_data_s = wb_data;
    end else begin
      rs1_data_s = reg_read_data;
    end
  end

  assign reg_read_addr = rs1_s;
  assign stall         = stall_s;

  hazard_unit #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard (
    .ifid_valid  (ifid_valid_r),
    .rs1_used    (rs1_used_s),
    .rs1         (rs1_s),
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .flush       (flush),
    .hazard      (hazard_s),
    .stall       (stall_s)
  );

  // IF/ID register: flush kills, stall holds, otherwise accept fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifid_instr_r <= 32'h0000_0000;
      ifid_pc_r    <= {PC_W{1'b0}};
      ifid_valid_r <= 1'b0;
    end else if (flush) begin
      ifid_valid_r <= 1'b0;
    end else if (!stall_s) begin
      ifid_instr_r <= if_instr;
      ifid_pc_r    <= if_pc;
      ifid_valid_r <= if_valid;
    end
  end

  // ID/EX register: bubble on flush or hazard (payload held), else capture decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      ex_pc        <= {PC_W{1'b0}};
      ex_rs1_data  <= {DATA_W{1'b0}};
      ex_imm       <= {DATA_W{1'b0}};
      ex_rd        <= {REG_ADDR_W{1'b0}};
      ex_alu_op    <= 3'b000;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_illegal   <= 1'b0;
    end else if (flush || hazard_s) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_illegal   <= 1'b0;
    end else begin
      ex_valid     <= ifid_valid_r;
      ex_pc        <= ifid_pc_r;
      ex_rs1_data  <= rs1_data_s;
      ex_imm       <= imm_s;
      ex_rd        <= rd_s;
      ex_alu_op    <= ctrl_s.alu_op;
      ex_reg_write <= ifid_valid_r & ctrl_s.reg_write;
      ex_mem_read  <= ifid_valid_r & ctrl_s.mem_read;
      ex_illegal   <= ifid_valid_r & ctrl_s.illegal;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed test-plan steps followed by
// randomized traffic, all compared against a transaction-level reference.
module tb_decode_stage;

  localparam logic [31:0] I_ADDI_2_1_5 = 32'h00508113;
  localparam logic [31:0] I_LB_3_1     = 32'h00008183;
  localparam logic [31:0] I_ADDI_4_3_1 = 32'h00118213;
  localparam logic [31:0] I_ADDI_6_0_3 = 32'h00300313;
  localparam logic [31:0] I_ADDI_7_1_9 = 32'h00908393;
  localparam logic [31:0] I_ADDI_5_0_7 = 32'h00700293;
  localparam logic [31:0] I_ILLEGAL    = 32'h00000033;

  logic        clk;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [7:0]  if_pc;
  logic        stall;
  logic        flush;
  logic [2:0]  reg_read_addr;
  logic [7:0]  reg_read_data;
  logic        wb_reg_write_en;
  logic [2:0]  wb_addr;
  logic [7:0]  wb_data;
  logic        ex_valid;
  logic [7:0]  ex_pc;
  logic [7:0]  ex_rs1_data;
  logic [7:0]  ex_imm;
  logic [2:0]  ex_rd;
  logic [2:0]  ex_alu_op;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_illegal;

  decode_stage #(.DATA_W(8), .REG_ADDR_W(3), .PC_W(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .if_valid        (if_valid),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .stall           (stall),
    .flush           (flush),
    .reg_read_addr   (reg_read_addr),
    .reg_read_data   (reg_read_data),
    .wb_reg_write_en (wb_reg_write_en),
    .wb_addr         (wb_addr),
    .wb_data         (wb_data),
    .ex_valid        (ex_valid),
    .ex_pc           (ex_pc),
    .ex_rs1_data     (ex_rs1_data),
    .ex_imm          (ex_imm),
    .ex_rd           (ex_rd),
    .ex_alu_op       (ex_alu_op),
    .ex_reg_write    (ex_reg_write),
    .ex_mem_read     (ex_mem_read),
    .ex_illegal      (ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural register file (combinational read).
  logic [7:0] rf [8];
  assign reg_read_data = rf[reg_read_addr];

  int vectors     = 0;
  int miscompares = 0;

  // Reference: the instruction sitting in decode and the one handed to execute.
  logic        m_ifid_valid;
  logic [31:0] m_ifid_instr;
  logic [7:0]  m_ifid_pc;
  logic        m_ex_valid, m_ex_rw, m_ex_mr, m_ex_ill;
  logic [7:0]  m_ex_pc, m_ex_rs1, m_ex_imm;
  logic [2:0]  m_ex_rd, m_ex_op;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic legal_op(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    return (op == 7'h13) || (op == 7'h03);
  endfunction

  task automatic model_reset();
    m_ifid_valid = 1'b0; m_ifid_instr = 32'h0; m_ifid_pc = 8'h00;
    m_ex_valid = 1'b0; m_ex_rw = 1'b0; m_ex_mr = 1'b0; m_ex_ill = 1'b0;
    m_ex_pc = 8'h00; m_ex_rs1 = 8'h00; m_ex_imm = 8'h00; m_ex_rd = 3'h0; m_ex_op = 3'h0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_stall"},     32'(stall), 32'h0);
    chk({tag, "_rdaddr"},    32'(reg_read_addr), 32'h0);
    chk({tag, "_ex_valid"},  32'(ex_valid), 32'h0);
    chk({tag, "_ex_pc"},     32'(ex_pc), 32'h0);
    chk({tag, "_ex_rs1"},    32'(ex_rs1_data), 32'h0);
    chk({tag, "_ex_imm"},    32'(ex_imm), 32'h0);
    chk({tag, "_ex_rd"},     32'(ex_rd), 32'h0);
    chk({tag, "_ex_aluop"},  32'(ex_alu_op), 32'h0);
    chk({tag, "_ex_rw"},     32'(ex_reg_write), 32'h0);
    chk({tag, "_ex_mr"},     32'(ex_mem_read), 32'h0);
    chk({tag, "_ex_ill"},    32'(ex_illegal), 32'h0);
  endtask

  // One clock cycle: drive, check combinational outputs, advance the reference, check ID/EX.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [7:0] pc,
                       input logic fl, input logic wbe, input logic [2:0] wba,
                       input logic [7:0] wbd, output logic es, output logic os);
    logic [2:0] rs1;
    logic       hz;
    logic       lg;
    if_valid = v; if_instr = ins; if_pc = pc; flush = fl;
    wb_reg_write_en = wbe; wb_addr = wba; wb_data = wbd;
    #1;
    rs1 = m_ifid_instr[17:15];
    lg  = legal_op(m_ifid_instr);
    hz  = m_ifid_valid && lg && m_ex_valid && m_ex_mr && (m_ex_rd == rs1);
    es  = hz && !fl;
    os  = stall;
    chk("stall", 32'(stall), 32'(es));
    chk("reg_read_addr", 32'(reg_read_addr), 32'(rs1));
    if (fl || hz) begin
      m_ex_valid = 1'b0; m_ex_rw = 1'b0; m_ex_mr = 1'b0; m_ex_ill = 1'b0;
    end else begin
      m_ex_valid = m_ifid_valid;
      m_ex_pc    = m_ifid_pc;
      m_ex_rs1   = (wbe && (wba == rs1)) ? wbd : rf[rs1];
      m_ex_imm   = m_ifid_instr[27:20];
      m_ex_rd    = m_ifid_instr[9:7];
      m_ex_op    = m_ifid_instr[14:12];
      m_ex_rw    = m_ifid_valid && lg;
      m_ex_mr    = m_ifid_valid && (m_ifid_instr[6:0] == 7'h03);
      m_ex_ill   = m_ifid_valid && !lg;
    end
    if (fl) begin
      m_ifid_valid = 1'b0;
    end else if (!es) begin
      m_ifid_valid = v; m_ifid_instr = ins; m_ifid_pc = pc;
    end
    @(posedge clk);
    #1;
    if (wbe) rf[wba] = wbd;
    chk("ex_valid", 32'(ex_valid), 32'(m_ex_valid));
    chk("ex_reg_write", 32'(ex_reg_write), 32'(m_ex_rw));
    chk("ex_mem_read", 32'(ex_mem_read), 32'(m_ex_mr));
    chk("ex_illegal", 32'(ex_illegal), 32'(m_ex_ill));
    if (m_ex_valid) begin
      chk("ex_pc", 32'(ex_pc), 32'(m_ex_pc));
      chk("ex_rs1_data", 32'(ex_rs1_data), 32'(m_ex_rs1));
      chk("ex_imm", 32'(ex_imm), 32'(m_ex_imm));
      chk("ex_rd", 32'(ex_rd), 32'(m_ex_rd));
      chk("ex_alu_op", 32'(ex_alu_op), 32'(m_ex_op));
    end
  endtask

  task automatic idle();
    logic es, os;
    cycle(1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 3'h0, 8'h00, es, os);
  endtask

  // Present an instruction, re-presenting while stalled (bounded); returns observed stall cycles.
  task automatic fetch(input logic [31:0] ins, input logic [7:0] pc, output int nstall);
    logic es, os;
    int   n;
    n = 0;
    nstall = 0;
    do begin
      cycle(1'b1, ins, pc, 1'b0, 1'b0, 3'h0, 8'h00, es, os);
      if (os) nstall++;
      n++;
    end while (es && n < 4);
  endtask

  initial begin
    int          ns;
    int          kind;
    logic        es, os, rv, fl;
    logic [31:0] rins;
    logic [7:0]  rpc;

    reset = 1'b1; if_valid = 1'b0; if_instr = 32'h0; if_pc = 8'h00; flush = 1'b0;
    wb_reg_write_en = 1'b0; wb_addr = 3'h0; wb_data = 8'h00;
    for (int i = 0; i < 8; i++) rf[i] = 8'(8'h20 + i);
    rf[1] = 8'h01;
    model_reset();
    #2;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // ADDI x2,x1,5 with x1=1
    fetch(I_ADDI_2_1_5, 8'h10, ns);
    idle();
    chk("addi_valid", 32'(ex_valid), 32'h1);
    chk("addi_rd", 32'(ex_rd), 32'h2);
    chk("addi_imm", 32'(ex_imm), 32'h5);
    chk("addi_rs1", 32'(ex_rs1_data), 32'h1);
    chk("addi_rw", 32'(ex_reg_write), 32'h1);
    chk("addi_mr", 32'(ex_mem_read), 32'h0);

    // Load-use: LB x3 then ADDI x4,x3,1
    fetch(I_LB_3_1, 8'h20, ns);
    fetch(I_ADDI_4_3_1, 8'h24, ns);
    fetch(I_ADDI_6_0_3, 8'h28, ns);
    chk("lu_stall_cycles", 32'(ns), 32'h1);
    chk("lu_issue_valid", 32'(ex_valid), 32'h1);
    chk("lu_issue_rd", 32'(ex_rd), 32'h4);
    chk("lu_issue_rs1", 32'(ex_rs1_data), 32'h23);
    idle();

    // Same-cycle write-back bypass of x1
    fetch(I_ADDI_7_1_9, 8'h30, ns);
    cycle(1'b0, 32'h0, 8'h00, 1'b0, 1'b1, 3'h1, 8'h7A, es, os);
    chk("bypass_rs1", 32'(ex_rs1_data), 32'h7A);
    chk("bypass_rd", 32'(ex_rd), 32'h7);

    // Flush together with a load-use hazard
    fetch(I_LB_3_1, 8'h40, ns);
    fetch(I_ADDI_4_3_1, 8'h44, ns);
    cycle(1'b1, I_ADDI_5_0_7, 8'h48, 1'b1, 1'b0, 3'h0, 8'h00, es, os);
    chk("flush_stall", 32'(os), 32'h0);
    chk("flush_bubble", 32'(ex_valid), 32'h0);
    idle();
    chk("flush_ifid_dead", 32'(ex_valid), 32'h0);
    fetch(I_ADDI_5_0_7, 8'h4C, ns);
    idle();
    chk("post_flush_valid", 32'(ex_valid), 32'h1);
    chk("post_flush_rd", 32'(ex_rd), 32'h5);
    chk("post_flush_imm", 32'(ex_imm), 32'h7);

    // Unknown opcode
    fetch(I_ILLEGAL, 8'h50, ns);
    idle();
    chk("ill_valid", 32'(ex_valid), 32'h1);
    chk("ill_flag", 32'(ex_illegal), 32'h1);
    chk("ill_rw", 32'(ex_reg_write), 32'h0);
    chk("ill_mr", 32'(ex_mem_read), 32'h0);

    // Randomized traffic with hazard-prone register indices
    es = 1'b0; rv = 1'b0; rins = 32'h0; rpc = 8'h00;
    for (int i = 0; i < 300; i++) begin
      if (!es) begin
        rv   = ($urandom % 4) != 0;
        rins = $urandom;
        kind = int'($urandom % 4);
        case (kind)
          0:       rins[6:0] = 7'h03;
          1, 2:    rins[6:0] = 7'h13;
          default: rins[6:0] = rins[6:0];
        endcase
        rins[17:15] = 3'($urandom_range(0, 3));
        rins[9:7]   = 3'($urandom_range(0, 3));
        rpc = 8'($urandom);
      end
      fl = ($urandom % 8) == 0;
      cycle(rv, rins, rpc, fl, 1'($urandom % 2), 3'($urandom % 8), 8'($urandom), es, os);
    end

    // Reset asserted during a stall cycle
    idle();
    idle();
    fetch(I_LB_3_1, 8'h60, ns);
    fetch(I_ADDI_4_3_1, 8'h64, ns);
    if_valid = 1'b0; flush = 1'b0; wb_reg_write_en = 1'b0;
    #1;
    chk("pre_reset_stall", 32'(stall), 32'h1);
    reset = 1'b1;
    #1;
    check_all_zero("mid_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    fetch(I_ADDI_5_0_7, 8'h70, ns);
    idle();
    chk("recover_valid", 32'(ex_valid), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
